// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas
//   Moore control unit for the sequence-memory game. Drives the clear /
//   count / load strobes of fluxo_dados and reports the game outcome.
//
// Ports
//   clock, reset           : system clock, async active-low reset
//   iniciar                : start / restart request (level)
//   jogada_feita           : one-cycle pulse, a play was made
//   jogada_correta         : registered play matches memory word
//   enderecoIgualRodada    : address counter == round counter
//   fimCR                  : round counter at last round
//   timeout                : play timeout expired
//   zeraR/registraR        : play register clear / load
//   zeraCR/contaCR         : round counter clear / increment
//   zeraCE/contaCE         : address counter clear / increment
//   zeraT/contaT           : timeout counter clear / enable
//   pronto, acertou, errou, perdeu_tempo : outcome flags
//   db_estado              : current state code (debug display)
module unidade_controle_rodadas (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimCR,
  input  logic       timeout,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraCE,
  output logic       contaCE,
  output logic       zeraT,
  output logic       contaT,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       perdeu_tempo,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } state_t;

  typedef struct packed {
    logic zr, rr, zcr, ccr, zce, cce, zt, ct, pr, ac, er, pt;
  } outs_t;

  state_t state, nxt;
  outs_t  outs;

  // Output decode of a state; used on the next state so the flags come
  // straight out of flops yet still track the state register exactly.
  function automatic outs_t decode(state_t s);
    outs_t o;
    o = '0;
    case (s)
      PREPARA:        begin o.zr = 1'b1; o.zcr = 1'b1; o.zce = 1'b1; o.zt = 1'b1; end
      INICIO_RODADA:  begin o.zce = 1'b1; o.zt = 1'b1; end
      ESPERA:         o.ct = 1'b1;
      REGISTRA:       begin o.rr = 1'b1; o.zt = 1'b1; end
      PROXIMA:        o.cce = 1'b1;
      PROXIMA_RODADA: o.ccr = 1'b1;
      FIM_ACERTO:     begin o.pr = 1'b1; o.ac = 1'b1; end
      FIM_TIMEOUT:    begin o.pr = 1'b1; o.pt = 1'b1; end
      FIM_ERRO:       begin o.pr = 1'b1; o.er = 1'b1; end
      default:        o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    nxt = INICIAL;
    case (state)
      INICIAL:        nxt = iniciar ? PREPARA : INICIAL;
      PREPARA:        nxt = INICIO_RODADA;
      INICIO_RODADA:  nxt = ESPERA;
      // A play wins over a timeout landing in the same cycle.
      ESPERA:         nxt = jogada_feita ? REGISTRA :
                            timeout      ? FIM_TIMEOUT : ESPERA;
      REGISTRA:       nxt = COMPARA;
      COMPARA: begin
        if (!jogada_correta)           nxt = FIM_ERRO;
        else if (!enderecoIgualRodada) nxt = PROXIMA;
        else if (fimCR)                nxt = FIM_ACERTO;
        else                           nxt = PROXIMA_RODADA;
      end
      PROXIMA:        nxt = ESPERA;
      PROXIMA_RODADA: nxt = INICIO_RODADA;
      FIM_ACERTO,
      FIM_TIMEOUT,
      FIM_ERRO:       nxt = iniciar ? PREPARA : state;
      default:        nxt = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INICIAL;
      outs  <= '0;
    end else begin
      state <= nxt;
      outs  <= decode(nxt);
    end
  end

  assign zeraR        = outs.zr;
  assign registraR    = outs.rr;
  assign zeraCR       = outs.zcr;
  assign contaCR      = outs.ccr;
  assign zeraCE       = outs.zce;
  assign contaCE      = outs.cce;
  assign zeraT        = outs.zt;
  assign contaT       = outs.ct;
  assign pronto       = outs.pr;
  assign acertou      = outs.ac;
  assign errou        = outs.er;
  assign perdeu_tempo = outs.pt;
  assign db_estado    = state;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
module tb_unidade_controle_rodadas;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, jogada_feita = 1'b0, jogada_correta = 1'b0;
  logic enderecoIgualRodada = 1'b0, fimCR = 1'b0, timeout = 1'b0;
  logic zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT;
  logic pronto, acertou, errou, perdeu_tempo;
  logic [3:0] db_estado;

  int tests = 0;
  int fails = 0;
  int model = 0;   // expected state code

  unidade_controle_rodadas dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .enderecoIgualRodada(enderecoIgualRodada), .fimCR(fimCR), .timeout(timeout),
    .zeraR(zeraR), .registraR(registraR), .zeraCR(zeraCR), .contaCR(contaCR),
    .zeraCE(zeraCE), .contaCE(contaCE), .zeraT(zeraT), .contaT(contaT),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .perdeu_tempo(perdeu_tempo), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Strobe table, bit order:
  // zeraR registraR zeraCR contaCR zeraCE contaCE zeraT contaT pronto acertou errou perdeu_tempo
  function automatic logic [11:0] expected_outs(int code);
    case (code)
      1:       return 12'b1010_1010_0000;
      2:       return 12'b0000_1010_0000;
      3:       return 12'b0000_0001_0000;
      4:       return 12'b0100_0010_0000;
      6:       return 12'b0000_0100_0000;
      7:       return 12'b0001_0000_0000;
      10:      return 12'b0000_0000_1100;
      13:      return 12'b0000_0000_1001;
      14:      return 12'b0000_0000_1010;
      default: return 12'b0;
    endcase
  endfunction

  // Game rules: where the controller goes from a given step.
  function automatic int rule_next(int code, logic ini, logic jf, logic ok,
                                   logic eq, logic fim, logic to);
    if (code == 0)                          return ini ? 1 : 0;
    if (code == 1)                          return 2;
    if (code == 2)                          return 3;
    if (code == 3)                          return jf ? 4 : (to ? 13 : 3);
    if (code == 4)                          return 5;
    if (code == 5)                          return !ok ? 14 : (!eq ? 6 : (fim ? 10 : 7));
    if (code == 6)                          return 3;
    if (code == 7)                          return 2;
    if (code == 10 || code == 13 || code == 14) return ini ? 1 : code;
    return 0;
  endfunction

  function automatic logic [11:0] dut_outs();
    return {zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT,
            pronto, acertou, errou, perdeu_tempo};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, {12'b0, db_estado}, model[15:0]);
    check({tag, ".outs"}, {4'b0, dut_outs()}, {4'b0, expected_outs(model)});
    // Outcome flags: exactly one when pronto, none otherwise.
    check({tag, ".onehot"},
          {15'b0, (pronto ? $countones({acertou, errou, perdeu_tempo}) == 1
                          : {acertou, errou, perdeu_tempo} == 3'b000)},
          16'h1);
  endtask

  // One clock edge; exp_code < 0 skips the directed state check.
  task automatic tick(input string tag, input int exp_code);
    int n;
    n = rule_next(model, iniciar, jogada_feita, jogada_correta,
                  enderecoIgualRodada, fimCR, timeout);
    @(posedge clock);
    model = reset ? n : 0;
    #1;
    check_all(tag);
    if (exp_code >= 0) check({tag, ".directed"}, {12'b0, db_estado}, exp_code[15:0]);
  endtask

  task automatic set_in(input logic ini, input logic jf, input logic ok,
                        input logic eq, input logic fim, input logic to);
    iniciar = ini; jogada_feita = jf; jogada_correta = ok;
    enderecoIgualRodada = eq; fimCR = fim; timeout = to;
  endtask

  initial begin
    // Reset held with start requested and inputs toggling.
    reset = 1'b0;
    #1;
    check_all("rst0");
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, i[0], ~i[0], i[1], i[0], ~i[1]);
      tick("rst_hold", 0);
    end
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick("idle", 0);
    tick("idle", 0);

    // Start, round 0 with a single correct play.
    set_in(1, 0, 0, 0, 0, 0); tick("start", 1);
    set_in(0, 0, 0, 0, 0, 0); tick("r0", 2);
    tick("r0", 3);
    tick("r0_wait", 3);
    set_in(0, 1, 1, 1, 0, 0); tick("r0_play", 4);
    set_in(0, 0, 1, 1, 0, 0); tick("r0_cmp", 5);
    tick("r0_next_round", 7);
    tick("r1_start", 2);
    tick("r1_wait", 3);

    // Intermediate play then a wrong one.
    set_in(0, 1, 1, 0, 0, 0); tick("mid_play", 4);
    set_in(0, 0, 1, 0, 0, 0); tick("mid_cmp", 5);
    tick("mid_next", 6);
    tick("mid_wait", 3);
    set_in(0, 1, 0, 1, 0, 0); tick("err_play", 4);
    set_in(0, 0, 0, 1, 0, 0); tick("err_cmp", 5);
    tick("err_end", 14);
    set_in(0, 1, 1, 1, 1, 1); tick("err_hold", 14);
    set_in(1, 0, 0, 0, 0, 0); tick("err_restart", 1);
    set_in(0, 0, 0, 0, 0, 0); tick("t_a", 2);
    tick("t_b", 3);

    // Timeout alone, then timeout colliding with a play.
    set_in(0, 0, 0, 0, 0, 1); tick("timeout", 13);
    set_in(0, 1, 1, 1, 1, 1); tick("to_hold", 13);
    set_in(1, 0, 0, 0, 0, 0); tick("to_restart", 1);
    set_in(0, 0, 0, 0, 0, 0); tick("c_a", 2);
    tick("c_b", 3);
    set_in(0, 1, 0, 0, 0, 1); tick("collide", 4);

    // Last-round win.
    set_in(0, 0, 1, 1, 1, 0); tick("win_cmp", 5);
    tick("win", 10);
    set_in(0, 1, 1, 1, 1, 1); tick("win_hold", 10);
    set_in(0, 0, 0, 0, 0, 0); tick("win_hold2", 10);

    // Async reset mid-game, before any clock edge.
    set_in(1, 0, 0, 0, 0, 0); tick("ar_a", 1);
    set_in(0, 0, 0, 0, 0, 0); tick("ar_b", 2);
    tick("ar_c", 3);
    reset = 1'b0;
    model = 0;
    #1;
    check_all("async_rst");
    check("async_rst.directed", {12'b0, db_estado}, 16'h0);
    tick("ar_hold", 0);
    reset = 1'b1;
    tick("ar_release", 0);

    // Randomised run against the rule model.
    for (int i = 0; i < 3000; i++) begin
      iniciar             = ($urandom_range(0, 9) == 0);
      jogada_feita        = ($urandom_range(0, 3) == 0);
      jogada_correta      = ($urandom_range(0, 9) != 0);
      enderecoIgualRodada = ($urandom_range(0, 2) == 0);
      fimCR               = ($urandom_range(0, 3) == 0);
      timeout             = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        model = 0;
        #1;
        check_all("rnd_rst");
        tick("rnd_rst_hold", 0);
        reset = 1'b1;
      end else begin
        tick("rnd", -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
